// File: rtl/cca_energy_detect.sv
// rtl/cca_energy_detect.sv - hysteresis clear-channel-assessment energy detector
//
// Turns the averaged, valid-strobed signal-strength stream into a registered
// channel-busy flag. Entering busy needs confirm_len consecutive HIGH samples.
// Leaving busy needs a LOW sample followed by hold_cycles clocks with no HIGH sample.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   data_in/_valid      signed averaged sample and its one-cycle strobe
//   thresh_busy/idle    signed enter-busy / leave-busy thresholds (live)
//   confirm_len         consecutive HIGH samples to declare busy (0 acts as 1)
//   hold_cycles         clocks without HIGH before returning idle
//   ch_busy             registered busy flag
//   busy_rise/fall      one-cycle pulses on ch_busy 0->1 / 1->0
//   busy_time           saturating busy duration; only present when
//                       CCA_BUSY_TIME_EN is defined, otherwise tied to 0
module cca_energy_detect #(
  parameter int DATA_WIDTH = 16,
  parameter int CONF_WIDTH = 4,
  parameter int HOLD_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_in_valid,
  input  logic signed [DATA_WIDTH-1:0] thresh_busy,
  input  logic signed [DATA_WIDTH-1:0] thresh_idle,
  input  logic        [CONF_WIDTH-1:0] confirm_len,
  input  logic        [HOLD_WIDTH-1:0] hold_cycles,
  output logic                         ch_busy,
  output logic                         busy_rise,
  output logic                         busy_fall,
  output logic        [HOLD_WIDTH-1:0] busy_time
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_BUSY = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CONF_WIDTH-1:0] conf_cnt_q, conf_cnt_d;
  logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                  ch_busy_q, busy_rise_q, busy_fall_q;
  logic                  busy_d;

  logic                  is_high, is_low;
  logic [CONF_WIDTH:0]   conf_eff;
  logic [CONF_WIDTH:0]   conf_plus1;
  logic [CONF_WIDTH-1:0] conf_inc;
  logic [HOLD_WIDTH-1:0] hold_inc;
  logic                  hold_expire;

  // HIGH wins when misconfigured thresholds make a sample both HIGH and LOW.
  assign is_high = data_in_valid && (data_in > thresh_busy);
  assign is_low  = data_in_valid && !is_high && (data_in < thresh_idle);

  // One bit wider so conf_cnt+1 compares correctly against an all-ones confirm_len.
  assign conf_eff   = (confirm_len == '0) ? (CONF_WIDTH+1)'(1) : {1'b0, confirm_len};
  assign conf_plus1 = {1'b0, conf_cnt_q} + (CONF_WIDTH+1)'(1);
  assign conf_inc   = (conf_cnt_q == '1) ? conf_cnt_q : conf_plus1[CONF_WIDTH-1:0];
  assign hold_inc   = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HOLD_WIDTH'(1);

  // >= rather than == so a live reduction of hold_cycles still terminates HOLD.
  assign hold_expire = (hold_cycles == '0) ||
                       (hold_cnt_q >= (hold_cycles - HOLD_WIDTH'(1)));

  always_comb begin
    state_d    = state_q;
    conf_cnt_d = conf_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (is_high) begin
          conf_cnt_d = CONF_WIDTH'(1);
          state_d    = (conf_eff == (CONF_WIDTH+1)'(1)) ? S_BUSY : S_PEND;
        end
      end
      S_PEND: begin
        if (is_high) begin
          conf_cnt_d = conf_inc;
          if (conf_plus1 >= conf_eff) begin
            state_d = S_BUSY;
          end
        end else if (data_in_valid) begin
          conf_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end
      S_BUSY: begin
        if (is_low) begin
          hold_cnt_d = '0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        hold_cnt_d = hold_inc;
        // A HIGH sample outranks a simultaneous expiry: stay busy, no fall pulse.
        if (is_high) begin
          hold_cnt_d = '0;
          state_d    = S_BUSY;
        end else if (hold_expire) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d == S_BUSY) || (state_d == S_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      conf_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      ch_busy_q   <= 1'b0;
      busy_rise_q <= 1'b0;
      busy_fall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      conf_cnt_q  <= conf_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      ch_busy_q   <= busy_d;
      busy_rise_q <= busy_d && !ch_busy_q;
      busy_fall_q <= !busy_d && ch_busy_q;
    end
  end

  assign ch_busy   = ch_busy_q;
  assign busy_rise = busy_rise_q;
  assign busy_fall = busy_fall_q;

`ifdef CCA_BUSY_TIME_EN
  logic [HOLD_WIDTH-1:0] busy_time_q;

  // Counts the current cycle too, so it reads 1 on the first busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_time_q <= '0;
    end else if (busy_d && !ch_busy_q) begin
      busy_time_q <= HOLD_WIDTH'(1);
    end else if (busy_d && ch_busy_q && (busy_time_q != '1)) begin
      busy_time_q <= busy_time_q + HOLD_WIDTH'(1);
    end
  end

  assign busy_time = busy_time_q;
`else
  assign busy_time = '0;
`endif

endmodule

// File: tb/tb_cca_energy_detect.sv
// tb/tb_cca_energy_detect.sv - self-checking bench for cca_energy_detect
module tb_cca_energy_detect;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int HW = 4;
`ifdef CCA_BUSY_TIME_EN
  localparam bit BT_EN = 1'b1;
`else
  localparam bit BT_EN = 1'b0;
`endif
  localparam int BT_MAX = (1 << HW) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] data_in;
  logic                 data_in_valid;
  logic signed [DW-1:0] thresh_busy;
  logic signed [DW-1:0] thresh_idle;
  logic        [CW-1:0] confirm_len;
  logic        [HW-1:0] hold_cycles;
  logic                 ch_busy;
  logic                 busy_rise;
  logic                 busy_fall;
  logic        [HW-1:0] busy_time;

  int total = 0;
  int bad   = 0;

  // Reference model state: busy flag, run of consecutive HIGH samples,
  // whether a hold-off is running and the cycle it started, busy duration.
  bit m_busy, m_rise, m_fall, m_holding;
  int m_run, m_enter, m_cyc, m_bt;

  cca_energy_detect #(
    .DATA_WIDTH(DW),
    .CONF_WIDTH(CW),
    .HOLD_WIDTH(HW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .thresh_busy  (thresh_busy),
    .thresh_idle  (thresh_idle),
    .confirm_len  (confirm_len),
    .hold_cycles  (hold_cycles),
    .ch_busy      (ch_busy),
    .busy_rise    (busy_rise),
    .busy_fall    (busy_fall),
    .busy_time    (busy_time)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input int d);
    data_in_valid = v;
    data_in       = DW'(d);
  endtask

  function automatic int exp_bt();
    return BT_EN ? m_bt : 0;
  endfunction

  // Advance one clock, update the model from the inputs seen at that edge,
  // then wait 1 time unit so DUT outputs are settled for checking.
  task automatic tick();
    int  d, tb_v, ti_v, need, hc;
    bit  hi, lo, prev;
    @(posedge clk);
    m_cyc++;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_holding = 1'b0; m_run = 0; m_bt = 0;
    end else begin
      d    = data_in;
      tb_v = thresh_busy;
      ti_v = thresh_idle;
      hc   = hold_cycles;
      need = (confirm_len == 0) ? 1 : int'(confirm_len);
      hi   = data_in_valid && (d > tb_v);
      lo   = data_in_valid && !hi && (d < ti_v);
      prev = m_busy;
      if (!m_busy) begin
        if (hi) begin
          m_run++;
          if (m_run >= need) begin
            m_busy = 1'b1; m_rise = 1'b1; m_holding = 1'b0;
          end
        end else if (data_in_valid) begin
          m_run = 0;
        end
      end else begin
        if (hi) begin
          m_holding = 1'b0;
        end else if (m_holding && (m_cyc - m_enter) >= hc) begin
          m_busy = 1'b0; m_fall = 1'b1; m_holding = 1'b0; m_run = 0;
        end else if (!m_holding && lo) begin
          m_holding = 1'b1;
          m_enter   = m_cyc;
        end
      end
      if (m_rise) m_bt = 1;
      else if (prev && m_busy && m_bt < BT_MAX) m_bt++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 0);
    tick();
    tick();
    total++; if (ch_busy !== 1'b0)   begin bad++; $display("FAIL reset_ch_busy got=%0b want=0", ch_busy); end
    total++; if (busy_rise !== 1'b0) begin bad++; $display("FAIL reset_rise got=%0b want=0", busy_rise); end
    total++; if (busy_fall !== 1'b0) begin bad++; $display("FAIL reset_fall got=%0b want=0", busy_fall); end
    total++; if (busy_time !== '0)   begin bad++; $display("FAIL reset_busy_time got=%0d want=0", busy_time); end
    rst = 1'b0;
  endtask

  task automatic test_confirmation();
    int s[6] = '{120, 120, 80, 120, 120, 120};
    int rises = 0;
    int rise_at = -1;
    thresh_busy = 100; thresh_idle = 50; confirm_len = 3; hold_cycles = 5;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, s[i]);
      tick();
      total++;
      if ({ch_busy, busy_rise, busy_fall} !== {m_busy, m_rise, m_fall} || busy_time !== HW'(exp_bt())) begin
        bad++;
        $display("FAIL confirm_step%0d got=%b/%0d want=%b%b%b/%0d", i, {ch_busy, busy_rise, busy_fall}, busy_time, m_busy, m_rise, m_fall, exp_bt());
      end
      if (busy_rise) begin rises++; rise_at = i + 1; end
      if (i == 1) begin
        total++;
        if (ch_busy !== 1'b0) begin bad++; $display("FAIL confirm_early got=%0b want=0", ch_busy); end
      end
    end
    drive(1'b0, 0);
    total++;
    if (rises !== 1 || rise_at !== 6) begin
      bad++;
      $display("FAIL confirm_rise got=%0d rises at strobe %0d want=1 at 6", rises, rise_at);
    end
  endtask

  task automatic test_hysteresis();
    int fall_at = -1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 80);
      tick();
      total++;
      if (ch_busy !== 1'b1 || {busy_rise, busy_fall} !== {m_rise, m_fall} || busy_time !== HW'(exp_bt())) begin
        bad++;
        $display("FAIL hyst_mid%0d got=%b%b%b/%0d want=1%b%b/%0d", i, ch_busy, busy_rise, busy_fall, busy_time, m_rise, m_fall, exp_bt());
      end
    end
    hold_cycles = 5;
    drive(1'b1, 40);
    for (int k = 1; k <= 20 && fall_at < 0; k++) begin
      tick();
      drive(1'b0, 0);
      if (busy_fall) fall_at = k;
    end
    total++;
    if (fall_at !== 6) begin bad++; $display("FAIL hyst_fall got=%0d want=6 cycles", fall_at); end
    total++;
    if (ch_busy !== m_busy) begin bad++; $display("FAIL hyst_idle got=%0b want=%0b", ch_busy, m_busy); end
  endtask

  task automatic test_hold_abort();
    int falls = 0;
    int fall_at = -1;
    confirm_len = 1; hold_cycles = 10;
    drive(1'b1, 120); tick();
    drive(1'b1, 40);  tick();
    drive(1'b0, 0);   tick(); tick(); tick();
    drive(1'b1, 120); tick();
    drive(1'b0, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy_fall || !ch_busy) falls++;
    end
    total++;
    if (falls !== 0 || m_busy !== 1'b1) begin bad++; $display("FAIL abort_stay got=%0d drop cycles want=0", falls); end
    drive(1'b1, 40);
    for (int k = 1; k <= 30 && fall_at < 0; k++) begin
      tick();
      drive(1'b0, 0);
      if (busy_fall) fall_at = k;
    end
    total++;
    if (fall_at !== 11) begin bad++; $display("FAIL abort_fall got=%0d want=11 cycles", fall_at); end
  endtask

  task automatic test_edge_configs();
    confirm_len = 0; hold_cycles = 0;
    drive(1'b1, 120); tick();
    total++;
    if (ch_busy !== 1'b1 || busy_rise !== 1'b1) begin bad++; $display("FAIL edge_conf0 got=%b%b want=11", ch_busy, busy_rise); end
    drive(1'b1, 40); tick();
    total++;
    if (ch_busy !== 1'b1 || busy_fall !== 1'b0) begin bad++; $display("FAIL edge_hold_entry got=%b%b want=10", ch_busy, busy_fall); end
    drive(1'b0, 0); tick();
    total++;
    if (ch_busy !== 1'b0 || busy_fall !== 1'b1) begin bad++; $display("FAIL edge_hold0 got=%b%b want=01", ch_busy, busy_fall); end
    thresh_idle = 200;
    drive(1'b1, 150); tick();
    total++;
    if (ch_busy !== 1'b1 || busy_rise !== m_rise) begin bad++; $display("FAIL edge_high_wins got=%b%b want=1%b", ch_busy, busy_rise, m_rise); end
    thresh_idle = 50;
    drive(1'b1, 40); tick();
    drive(1'b0, 0);  tick();
    total++;
    if (ch_busy !== 1'b0) begin bad++; $display("FAIL edge_back_idle got=%0b want=0", ch_busy); end
  endtask

  task automatic test_busy_time();
    int want;
    want = BT_EN ? BT_MAX : 0;
    confirm_len = 1; hold_cycles = 0;
    drive(1'b1, 120); tick();
    drive(1'b0, 0);
    for (int i = 0; i < 29; i++) tick();
    total++;
    if (busy_time !== HW'(want) || busy_time !== HW'(exp_bt())) begin
      bad++; $display("FAIL busy_time_sat got=%0d want=%0d", busy_time, want);
    end
    drive(1'b1, 40); tick();
    drive(1'b0, 0);  tick(); tick();
    total++;
    if (ch_busy !== 1'b0 || busy_time !== HW'(want)) begin
      bad++; $display("FAIL busy_time_hold got=%0b/%0d want=0/%0d", ch_busy, busy_time, want);
    end
  endtask

  task automatic test_reset_mid();
    thresh_busy = 100; confirm_len = 1;
    drive(1'b1, 120); tick();
    drive(1'b1, 80);  tick();
    total++;
    if (ch_busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%0b want=1", ch_busy); end
    rst = 1'b1;
    tick();
    total++;
    if ({ch_busy, busy_rise, busy_fall} !== 3'b000 || busy_time !== '0) begin
      bad++; $display("FAIL rstmid_post got=%b/%0d want=000/0", {ch_busy, busy_rise, busy_fall}, busy_time);
    end
    rst = 1'b0;
    drive(1'b0, 0);
    tick();
    total++;
    if (busy_fall !== 1'b0) begin bad++; $display("FAIL rstmid_nofall got=%0b want=0", busy_fall); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        thresh_busy = DW'(int'($urandom_range(0, 150)));
        thresh_idle = ($urandom_range(0, 9) == 0) ? DW'(int'($urandom_range(150, 250)))
                                                  : DW'(int'($urandom_range(0, 100)) - 50);
        confirm_len = CW'($urandom_range(0, 5));
        hold_cycles = HW'($urandom_range(0, 6));
      end
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 2) != 0, int'($urandom_range(0, 300)) - 100);
      tick();
      total++;
      if ({ch_busy, busy_rise, busy_fall} !== {m_busy, m_rise, m_fall} || busy_time !== HW'(exp_bt())) begin
        bad++;
        $display("FAIL random_cyc%0d got=%b/%0d want=%b%b%b/%0d", i, {ch_busy, busy_rise, busy_fall}, busy_time, m_busy, m_rise, m_fall, exp_bt());
      end
      total++;
      if (busy_rise && busy_fall) begin bad++; $display("FAIL random_both_pulses cyc%0d got=11 want=not both", i); end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_busy = 0; m_rise = 0; m_fall = 0; m_holding = 0;
    m_run = 0; m_enter = 0; m_cyc = 0; m_bt = 0;
    rst = 1'b1;
    data_in = '0; data_in_valid = 1'b0;
    thresh_busy = 100; thresh_idle = 50;
    confirm_len = 3; hold_cycles = 5;
    test_reset();
    test_confirmation();
    test_hysteresis();
    test_hold_abort();
    test_edge_configs();
    test_busy_time();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
